// File: rtl/matrix_scan_ctrl.sv
// 8x8 LED matrix scanner with a point-table frame builder.
// Rebuilt frames are double-buffered and swapped only at a frame boundary.
module matrix_scan_ctrl #(
  parameter int DWELL = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pt_wr,
  input  logic [2:0] pt_idx,
  input  logic [2:0] pt_x,
  input  logic [2:0] pt_y,
  input  logic       pt_valid,
  input  logic       frame_req,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] row_sel,
  output logic [7:0] col_data
);

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    BUILD,
    PEND
  } state_t;

  state_t      state;
  logic [7:0]  pt_v;
  logic [2:0]  pt_xs [8];
  logic [2:0]  pt_ys [8];
  logic [7:0]  shadow [8];
  logic [7:0]  display [8];
  logic [15:0] dwell;
  logic [2:0]  row;
  logic [2:0]  bidx;

  logic       wrap;
  logic       boundary;
  logic       pre_bnd;
  logic       swap;
  logic [2:0] row_nx;

  assign wrap     = dwell == 16'(DWELL - 1);
  assign boundary = wrap && (row == 3'd7);
  assign pre_bnd  = (row == 3'd7) && (dwell == 16'(DWELL - 2));
  assign swap     = (state == PEND) && boundary;
  assign row_nx   = row + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      pt_v       <= '0;
      dwell      <= '0;
      row        <= '0;
      bidx       <= '0;
      state      <= IDLE;
      row_sel    <= 8'h80;
      col_data   <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        pt_xs[i]   <= '0;
        pt_ys[i]   <= '0;
        shadow[i]  <= '0;
        display[i] <= '0;
      end
    end else begin
      if (pt_wr) begin
        pt_v[pt_idx]  <= pt_valid;
        pt_xs[pt_idx] <= pt_x;
        pt_ys[pt_idx] <= pt_y;
      end

      dwell <= wrap ? 16'd0 : dwell + 16'd1;
      if (wrap) begin
        row     <= row_nx;
        row_sel <= 8'h80 >> row_nx;
        col_data <= swap ? shadow[row_nx] : display[row_nx];
      end

      if (swap) begin
        for (int i = 0; i < 8; i++)
          display[i] <= shadow[i];
      end

      // Pulse lands on the boundary cycle itself, so predict it a cycle early.
      frame_done <= pre_bnd &&
                    ((state == PEND) ||
                     ((state == BUILD) && (bidx == 3'd7)));

      unique case (state)
        IDLE: begin
          if (frame_req) begin
            state <= CLR;
            busy  <= 1'b1;
          end
        end
        CLR: begin
          for (int i = 0; i < 8; i++)
            shadow[i] <= '0;
          bidx  <= '0;
          state <= BUILD;
        end
        BUILD: begin
          if (pt_v[bidx])
            shadow[pt_ys[bidx]] <= shadow[pt_ys[bidx]] |
                                   (8'h80 >> pt_xs[bidx]);
          bidx <= bidx + 3'd1;
          if (bidx == 3'd7)
            state <= PEND;
        end
        PEND: begin
          if (boundary) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl: cycle model from frame arithmetic,
// directed scenarios with literal checks, then random traffic.
module tb_matrix_scan_ctrl;

  localparam int D  = 4;
  localparam int FR = 8 * D;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pt_wr = 1'b0;
  logic [2:0] pt_idx = '0;
  logic [2:0] pt_x = '0;
  logic [2:0] pt_y = '0;
  logic       pt_valid = 1'b0;
  logic       frame_req = 1'b0;
  logic       busy;
  logic       frame_done;
  logic [7:0] row_sel;
  logic [7:0] col_data;

  matrix_scan_ctrl #(.DWELL(D)) dut (
    .clk(clk),
    .rst(rst),
    .pt_wr(pt_wr),
    .pt_idx(pt_idx),
    .pt_x(pt_x),
    .pt_y(pt_y),
    .pt_valid(pt_valid),
    .frame_req(frame_req),
    .busy(busy),
    .frame_done(frame_done),
    .row_sel(row_sel),
    .col_data(col_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model: k = cycles since reset, cyc = absolute cycle number
  int         k = 0;
  int         cyc = 0;
  bit         armed = 0;
  bit         pend = 0;
  int         t_req = 0;
  bit         m_v [8];
  logic [2:0] m_x [8];
  logic [2:0] m_y [8];
  logic [7:0] m_disp [8];
  logic [7:0] m_shad [8];
  int         fd_cnt = 0;
  int         busy_cnt = 0;

  function automatic bit exp_fd();
    return pend && (cyc >= t_req + 10) && ((k % FR) == FR - 1);
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d k=%0d)",
               nm, act, exp, cyc, k);
    end
  endtask

  task automatic model_step();
    bit fd;
    int i;
    if (rst) begin
      for (int j = 0; j < 8; j++) begin
        m_v[j] = 0;
        m_disp[j] = '0;
        m_shad[j] = '0;
      end
      pend = 0;
      k = 0;
      armed = 1;
    end else begin
      fd = exp_fd();
      if (pend) begin
        i = cyc - t_req - 2;
        if (i >= 0 && i < 8 && m_v[i])
          m_shad[m_y[i]] = m_shad[m_y[i]] | (8'h80 >> m_x[i]);
        if (fd) begin
          for (int j = 0; j < 8; j++) m_disp[j] = m_shad[j];
          pend = 0;
        end
      end else if (frame_req) begin
        pend = 1;
        t_req = cyc;
        for (int j = 0; j < 8; j++) m_shad[j] = '0;
      end
      if (pt_wr) begin
        m_v[pt_idx] = pt_valid;
        m_x[pt_idx] = pt_x;
        m_y[pt_idx] = pt_y;
      end
      k++;
    end
    cyc++;
  endtask

  task automatic compare();
    int r;
    if (!armed) return;
    r = (k / D) % 8;
    chk("busy", {7'b0, busy}, {7'b0, pend});
    chk("frame_done", {7'b0, frame_done}, {7'b0, exp_fd()});
    chk("row_sel", row_sel, 8'h80 >> r);
    chk("col_data", col_data, m_disp[r]);
    if (frame_done === 1'b1) fd_cnt++;
    if (busy === 1'b1) busy_cnt++;
  endtask

  task automatic cyc_go();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic drive_cycle();
    cyc_go();
    pt_wr = 1'b0;
    frame_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle();
  endtask

  task automatic wr(input int i, input int x, input int y, input bit v);
    pt_wr = 1'b1;
    pt_idx = 3'(i);
    pt_x = 3'(x);
    pt_y = 3'(y);
    pt_valid = v;
    drive_cycle();
  endtask

  task automatic req();
    frame_req = 1'b1;
    drive_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cyc_go();
    rst = 1'b0;
  endtask

  task automatic align();
    while ((k % FR) != 0) idle(1);
  endtask

  int fd0;
  int b0;

  initial begin
    do_reset();
    chk("rst_row_sel", row_sel, 8'h80);
    chk("rst_col", col_data, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);

    idle(40);
    chk("idle_busy", {7'b0, busy}, 8'h00);

    // two corner points, request exactly at a frame start
    wr(0, 0, 0, 1);
    wr(1, 7, 7, 1);
    align();
    fd0 = fd_cnt;
    b0 = busy_cnt;
    req();
    idle(FR + 4);
    chk("corner_fd_count", 8'(fd_cnt - fd0), 8'd1);
    chk("corner_busy_len", 8'(busy_cnt - b0), 8'd31);
    align();
    chk("corner_row0", col_data, 8'h80);
    idle(28);
    chk("corner_row7_sel", row_sel, 8'h01);
    chk("corner_row7", col_data, 8'h01);

    // duplicate points merge
    wr(2, 3, 2, 1);
    wr(3, 3, 2, 1);
    align();
    req();
    idle(40);
    chk("dup_row2", col_data, 8'h10);

    // extra requests while busy are dropped
    align();
    fd0 = fd_cnt;
    req();
    idle(2);
    req();
    idle(3);
    req();
    idle(3);
    req();
    idle(80);
    chk("multi_req_fd", 8'(fd_cnt - fd0), 8'd1);
    chk("multi_req_idle", {7'b0, busy}, 8'h00);

    // clearing slot0: old row 0 stays until the swap
    wr(0, 0, 0, 0);
    align();
    req();
    chk("clr_row0_old", col_data, 8'h80);
    idle(31);
    chk("clr_row0_new", col_data, 8'h00);

    // reset in PEND aborts the rebuild
    align();
    req();
    idle(14);
    fd0 = fd_cnt;
    rst = 1'b1;
    cyc_go();
    rst = 1'b0;
    chk("abort_row_sel", row_sel, 8'h80);
    chk("abort_col", col_data, 8'h00);
    chk("abort_busy", {7'b0, busy}, 8'h00);
    idle(40);
    chk("abort_no_fd", 8'(fd_cnt - fd0), 8'd0);
    align();
    req();
    idle(FR + 2);
    chk("abort_rebuild_zero", col_data, 8'h00);

    // write into the slot being visited uses the old entry
    wr(4, 1, 1, 1);
    align();
    req();
    idle(5);
    wr(4, 5, 5, 0);
    idle(29);
    chk("same_cycle_row1", col_data, 8'h40);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        pt_wr = 1'b1;
        pt_idx = 3'($urandom_range(0, 7));
        pt_x = 3'($urandom_range(0, 7));
        pt_y = 3'($urandom_range(0, 7));
        pt_valid = 1'($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 19) == 0) frame_req = 1'b1;
      drive_cycle();
      rst = 1'b0;
    end
    idle(FR * 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
